// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg
//   Shared definitions for the data-memory bridge:
//   - state_e           : bridge FSM states (IDLE, REQ, WAIT_R, DONE)
//   - TIMEOUT_CYCLES_DEF: default bus-wait limit in cycles
//   - WORD_ALIGN_MASK   : clears the byte-offset bits of a byte address
//   - is_word_aligned() : true when a byte address lies on a word boundary
package dmem_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int          TIMEOUT_CYCLES_DEF = 255;
   localparam logic [31:0] WORD_ALIGN_MASK    = 32'hFFFF_FFFC;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr & ~WORD_ALIGN_MASK) == 32'd0;
   endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if
//   Word-wide RAM bus with a request/grant/response handshake.
//   - mem_req    : request, held until granted
//   - mem_we     : 1 = write, 0 = read
//   - mem_addr   : word address (bits [1:0] always 0)
//   - mem_wdata  : store data
//   - mem_gnt    : RAM accepts the request this cycle
//   - mem_rvalid : read data valid
//   - mem_rdata  : read data
//   Modports: master (bridge side), slave (RAM side).
interface dmem_bridge_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// dmem_timeout_ctr
//   Bus-wait cycle counter for the data-memory bridge.
//   Ports:
//   - clk_cpu, reset : clock and synchronous active-high reset
//   - clear          : restart counting (asserted on entry to a transaction)
//   - enable         : count this cycle (bridge is waiting on the bus)
//   - expired        : the current waiting cycle is cycle number LIMIT
//   Counting stops once expired so the register never wraps.
module dmem_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clk_cpu,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count_reg;

   // count_reg holds the number of waiting cycles already completed, so the
   // LIMIT-th waiting cycle sees LIMIT-1.
   assign expired = enable && (count_reg >= CW'(LIMIT - 1));

   always_ff @(posedge clk_cpu) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (enable && !expired) begin
         count_reg <= count_reg + CW'(1);
      end
   end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Multi-cycle bridge between a single-cycle CPU load/store port and a
//   word-wide RAM with request/grant/response handshake. The CPU is frozen
//   with cpu_stall while a transaction runs and released in the DONE cycle.
//   Ports:
//   - clk_cpu, reset            : clock, synchronous active-high reset
//   - cpu_mem_read/cpu_mem_write: load / store in the current instruction
//   - cpu_addr, cpu_wdata       : byte address and store data
//   - cpu_rdata                 : load data, valid in the DONE cycle
//   - cpu_stall                 : freezes PC and register write
//   - bus (dmem_bridge_if.master): RAM bus
//   - align_err                 : one-cycle pulse on a misaligned access
//   - timeout_err               : sticky bus-timeout flag
//   Optional feature: define DMEM_BRIDGE_TIMEOUT_EN to abort transactions
//   that wait TIMEOUT_CYCLES cycles; otherwise the bridge waits forever and
//   timeout_err is tied low.
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                 clk_cpu,
   input  logic                 reset,
   input  logic                 cpu_mem_read,
   input  logic                 cpu_mem_write,
   input  logic [31:0]          cpu_addr,
   input  logic [31:0]          cpu_wdata,
   output logic [31:0]          cpu_rdata,
   output logic                 cpu_stall,
   dmem_bridge_if.master        bus,
   output logic                 align_err,
   output logic                 timeout_err
);

   state_e      state_reg, state_next;
   logic        mem_req_reg;
   logic        mem_we_reg;
   logic [31:0] mem_addr_reg;
   logic [31:0] mem_wdata_reg;
   logic [31:0] rdata_reg;

   logic        accept;       // aligned access taken in IDLE
   logic        capture;      // read data returned this cycle
   logic        timeout_hit;  // transaction aborted this cycle
   logic        expired;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
   logic timeout_err_reg;

   dmem_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk_cpu (clk_cpu),
      .reset   (reset),
      .clear   (accept),
      .enable  ((state_reg == ST_REQ) || (state_reg == ST_WAIT_R)),
      .expired (expired)
   );

   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         timeout_err_reg <= 1'b0;
      end else if (timeout_hit) begin
         timeout_err_reg <= 1'b1;
      end
   end

   assign timeout_err = timeout_err_reg;
`else
   assign expired     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      accept      = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      align_err   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (cpu_mem_read || cpu_mem_write) begin
               if (is_word_aligned(cpu_addr)) begin
                  accept     = 1'b1;
                  state_next = ST_REQ;
               end else begin
                  align_err  = 1'b1;
               end
            end
         end
         ST_REQ: begin
            // A grant always wins over an expiring counter; a read granted
            // without data falls into WAIT_R where the counter is still live.
            if (bus.mem_gnt) begin
               if (mem_we_reg) begin
                  state_next = ST_DONE;
               end else if (bus.mem_rvalid) begin
                  capture    = 1'b1;
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_WAIT_R;
               end
            end else if (expired) begin
               timeout_hit = 1'b1;
               state_next  = ST_DONE;
            end
         end
         ST_WAIT_R: begin
            if (bus.mem_rvalid) begin
               capture    = 1'b1;
               state_next = ST_DONE;
            end else if (expired) begin
               timeout_hit = 1'b1;
               state_next  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         rdata_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         // Request is high for exactly the cycles spent in REQ.
         mem_req_reg <= (state_next == ST_REQ);
         if (accept) begin
            mem_addr_reg  <= cpu_addr & WORD_ALIGN_MASK;
            mem_wdata_reg <= cpu_wdata;
            mem_we_reg    <= cpu_mem_write;
            rdata_reg     <= '0;
         end
         if (capture) begin
            rdata_reg <= bus.mem_rdata;
         end else if (timeout_hit) begin
            rdata_reg <= '0;
         end
      end
   end

   assign cpu_stall     = accept || (state_reg == ST_REQ) || (state_reg == ST_WAIT_R);
   assign cpu_rdata     = align_err ? 32'd0 : rdata_reg;
   assign bus.mem_req   = mem_req_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
//   Directed, table-driven bench for dmem_bridge. Each table row is one
//   clock cycle: CPU/bus inputs plus the outputs expected in that cycle.
//   Reset behaviour, reset mid-transaction and (with DMEM_BRIDGE_TIMEOUT_EN)
//   the timeout path are hand-written sequences.
module tb_dmem_bridge;

   logic        clk_cpu = 1'b0;
   logic        reset;
   logic        cpu_mem_read;
   logic        cpu_mem_write;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        align_err;
   logic        timeout_err;

   dmem_bridge_if bus_if ();

   dmem_bridge #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_cpu       (clk_cpu),
      .reset         (reset),
      .cpu_mem_read  (cpu_mem_read),
      .cpu_mem_write (cpu_mem_write),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_rdata     (cpu_rdata),
      .cpu_stall     (cpu_stall),
      .bus           (bus_if),
      .align_err     (align_err),
      .timeout_err   (timeout_err)
   );

   always #5 clk_cpu = ~clk_cpu;

   typedef struct {
      string       nm;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        e_stall;
      logic        e_req;
      logic        e_align;
      logic        chk_bus;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        chk_rd;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input string nm,
                               input logic rd, wr, input logic [31:0] addr, wdata,
                               input logic gnt, rv, input logic [31:0] rdata,
                               input logic e_stall, e_req, e_align,
                               input logic chk_bus, e_we, input logic [31:0] e_addr, e_wdata,
                               input logic chk_rd, input logic [31:0] e_rdata);
      vec_t v;
      v.nm = nm; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.gnt = gnt; v.rv = rv; v.rdata = rdata;
      v.e_stall = e_stall; v.e_req = e_req; v.e_align = e_align;
      v.chk_bus = chk_bus; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
      v.chk_rd = chk_rd; v.e_rdata = e_rdata;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rd, wr, input logic [31:0] addr, wdata,
                        input logic gnt, rv, input logic [31:0] rdata);
      cpu_mem_read      = rd;
      cpu_mem_write     = wr;
      cpu_addr          = addr;
      cpu_wdata         = wdata;
      bus_if.mem_gnt    = gnt;
      bus_if.mem_rvalid = rv;
      bus_if.mem_rdata  = rdata;
   endtask

   initial begin
      // Store: granted at first REQ cycle, 2 stall cycles.
      vecs.push_back(mk("st_idle", 0,1,32'h10,32'hCAFEF00D, 0,0,0, 1,0,0, 0,0,0,0, 1,0));
      vecs.push_back(mk("st_req",  0,1,32'h10,32'hCAFEF00D, 1,0,0, 1,1,0, 1,1,32'h10,32'hCAFEF00D, 0,0));
      vecs.push_back(mk("st_done", 0,1,32'h10,32'hCAFEF00D, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
      vecs.push_back(mk("st_next", 0,0,0,0,                 0,0,0, 0,0,0, 0,0,0,0, 0,0));
      // Load: grant after 3 waiting cycles, data 2 cycles after the grant.
      vecs.push_back(mk("ld_idle", 1,0,32'h20,0, 0,0,0,            1,0,0, 0,0,0,0, 0,0));
      vecs.push_back(mk("ld_req1", 1,0,32'h20,0, 0,0,0,            1,1,0, 1,0,32'h20,0, 0,0));
      vecs.push_back(mk("ld_req2", 1,0,32'h20,0, 0,0,0,            1,1,0, 1,0,32'h20,0, 0,0));
      vecs.push_back(mk("ld_req3", 1,0,32'h20,0, 0,0,0,            1,1,0, 1,0,32'h20,0, 0,0));
      vecs.push_back(mk("ld_gnt",  1,0,32'h20,0, 1,0,0,            1,1,0, 1,0,32'h20,0, 0,0));
      vecs.push_back(mk("ld_wr1",  1,0,32'h20,0, 0,0,32'hDEADBEEF, 1,0,0, 0,0,0,0, 1,0));
      vecs.push_back(mk("ld_wr2",  1,0,32'h20,0, 0,1,32'h12345678, 1,0,0, 0,0,0,0, 0,0));
      vecs.push_back(mk("ld_done", 1,0,32'h20,0, 0,0,0,            0,0,0, 0,0,0,0, 1,32'h12345678));
      vecs.push_back(mk("ld_next", 0,0,0,0,      0,0,0,            0,0,0, 0,0,0,0, 0,0));
      // Misaligned load and store: pulse, no stall, no bus, rdata 0.
      vecs.push_back(mk("mis_ld",  1,0,32'h22,0,            0,0,0, 0,0,1, 0,0,0,0, 1,0));
      vecs.push_back(mk("mis_ld1", 0,0,0,0,                 0,0,0, 0,0,0, 0,0,0,0, 0,0));
      vecs.push_back(mk("mis_st",  0,1,32'h13,32'h11111111, 0,0,0, 0,0,1, 0,0,0,0, 1,0));
      vecs.push_back(mk("mis_st1", 0,0,0,0,                 0,0,0, 0,0,0, 0,0,0,0, 0,0));
      // Back-to-back: load (data with the grant) then store.
      vecs.push_back(mk("bb_ld",   1,0,32'h40,0,            0,0,0,            1,0,0, 0,0,0,0, 0,0));
      vecs.push_back(mk("bb_ldg",  1,0,32'h40,0,            1,1,32'hA5A50001, 1,1,0, 1,0,32'h40,0, 0,0));
      vecs.push_back(mk("bb_ldd",  1,0,32'h40,0,            0,0,0,            0,0,0, 0,0,0,0, 1,32'hA5A50001));
      vecs.push_back(mk("bb_st",   0,1,32'h44,32'h0BADF00D, 0,0,0,            1,0,0, 0,0,0,0, 0,0));
      vecs.push_back(mk("bb_stg",  0,1,32'h44,32'h0BADF00D, 1,0,0,            1,1,0, 1,1,32'h44,32'h0BADF00D, 0,0));
      vecs.push_back(mk("bb_std",  0,1,32'h44,32'h0BADF00D, 0,0,0,            0,0,0, 0,0,0,0, 0,0));
      vecs.push_back(mk("bb_next", 0,0,0,0,                 0,0,0,            0,0,0, 0,0,0,0, 0,0));
      // Read and write both set: write wins.
      vecs.push_back(mk("rw_idle", 1,1,32'h80,32'h77777777, 0,0,0, 1,0,0, 0,0,0,0, 0,0));
      vecs.push_back(mk("rw_gnt",  1,1,32'h80,32'h77777777, 1,0,0, 1,1,0, 1,1,32'h80,32'h77777777, 0,0));
      vecs.push_back(mk("rw_done", 1,1,32'h80,32'h77777777, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
      // Stray rvalid in IDLE must not start or stall anything.
      vecs.push_back(mk("stray_rv", 0,0,0,0, 0,1,32'hFFFFFFFF, 0,0,0, 0,0,0,0, 0,0));
      vecs.push_back(mk("stray_1",  0,0,0,0, 0,0,0,            0,0,0, 0,0,0,0, 0,0));

      // Reset values.
      reset = 1'b1;
      drive(0,0,0,0, 0,0,0);
      repeat (3) @(negedge clk_cpu);
      #1;
      chk("rst_stall", {31'd0, cpu_stall}, 0);
      chk("rst_req",   {31'd0, bus_if.mem_req}, 0);
      chk("rst_we",    {31'd0, bus_if.mem_we}, 0);
      chk("rst_addr",  bus_if.mem_addr, 0);
      chk("rst_wdata", bus_if.mem_wdata, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_tmo",   {31'd0, timeout_err}, 0);
      $display("txn reset: stall=%0b req=%0b rdata=%h", cpu_stall, bus_if.mem_req, cpu_rdata);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_cpu);
         drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
         #1;
         chk({vecs[i].nm, "_stall"}, {31'd0, cpu_stall}, {31'd0, vecs[i].e_stall});
         chk({vecs[i].nm, "_req"},   {31'd0, bus_if.mem_req}, {31'd0, vecs[i].e_req});
         chk({vecs[i].nm, "_align"}, {31'd0, align_err}, {31'd0, vecs[i].e_align});
         if (vecs[i].chk_bus) begin
            chk({vecs[i].nm, "_we"},   {31'd0, bus_if.mem_we}, {31'd0, vecs[i].e_we});
            chk({vecs[i].nm, "_addr"}, bus_if.mem_addr, vecs[i].e_addr);
            if (vecs[i].e_we)
               chk({vecs[i].nm, "_wdata"}, bus_if.mem_wdata, vecs[i].e_wdata);
         end
         if (vecs[i].chk_rd)
            chk({vecs[i].nm, "_rdata"}, cpu_rdata, vecs[i].e_rdata);
         $display("txn %0d %s: stall=%0b req=%0b we=%0b addr=%h align=%0b rdata=%h",
                  i, vecs[i].nm, cpu_stall, bus_if.mem_req, bus_if.mem_we,
                  bus_if.mem_addr, align_err, cpu_rdata);
      end
      chk("tbl_tmo", {31'd0, timeout_err}, 0);

      // Reset while waiting for read data, then a late rvalid.
      @(negedge clk_cpu); drive(1,0,32'h60,0, 0,0,0); #1;
      chk("mrst_stall0", {31'd0, cpu_stall}, 1);
      @(negedge clk_cpu); drive(1,0,32'h60,0, 1,0,0); #1;
      chk("mrst_req", {31'd0, bus_if.mem_req}, 1);
      @(negedge clk_cpu); drive(1,0,32'h60,0, 0,0,0); #1;
      chk("mrst_wait_stall", {31'd0, cpu_stall}, 1);
      chk("mrst_wait_req",   {31'd0, bus_if.mem_req}, 0);
      reset = 1'b1;
      @(negedge clk_cpu);
      reset = 1'b0;
      drive(0,0,0,0, 0,1,32'hFFFF0000); #1;
      chk("mrst_req0",  {31'd0, bus_if.mem_req}, 0);
      chk("mrst_we0",   {31'd0, bus_if.mem_we}, 0);
      chk("mrst_addr0", bus_if.mem_addr, 0);
      chk("mrst_rd0",   cpu_rdata, 0);
      chk("mrst_stl0",  {31'd0, cpu_stall}, 0);
      @(negedge clk_cpu); drive(0,0,0,0, 0,0,0); #1;
      chk("mrst_late_rd",  cpu_rdata, 0);
      chk("mrst_late_stl", {31'd0, cpu_stall}, 0);
      chk("mrst_late_req", {31'd0, bus_if.mem_req}, 0);
      $display("txn mid_reset: stall=%0b req=%0b rdata=%h", cpu_stall, bus_if.mem_req, cpu_rdata);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
      // No grant: 8 REQ cycles, then DONE with timeout_err set and sticky.
      @(negedge clk_cpu); drive(1,0,32'h100,0, 0,0,0); #1;
      chk("tmo_idle_stall", {31'd0, cpu_stall}, 1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_cpu); #1;
         chk("tmo_wait_req",   {31'd0, bus_if.mem_req}, 1);
         chk("tmo_wait_stall", {31'd0, cpu_stall}, 1);
         chk("tmo_wait_flag",  {31'd0, timeout_err}, 0);
      end
      @(negedge clk_cpu); #1;
      chk("tmo_done_stall", {31'd0, cpu_stall}, 0);
      chk("tmo_done_req",   {31'd0, bus_if.mem_req}, 0);
      chk("tmo_done_flag",  {31'd0, timeout_err}, 1);
      chk("tmo_done_rdata", cpu_rdata, 0);
      @(negedge clk_cpu); drive(0,0,0,0, 0,0,0);
      repeat (3) @(negedge clk_cpu);
      #1;
      chk("tmo_sticky", {31'd0, timeout_err}, 1);
      reset = 1'b1;
      @(negedge clk_cpu);
      reset = 1'b0;
      #1;
      chk("tmo_cleared", {31'd0, timeout_err}, 0);
      $display("txn timeout: flag=%0b", timeout_err);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Multi-cycle data-memory bridge between the single-cycle CPU's load/store port and an external word-wide RAM with a request/grant/response handshake. It latches each load or store, runs the bus transaction, and holds the CPU frozen with `cpu_stall` until the data is returned or the write is accepted. The CPU advances PC and commits its register write only when `cpu_stall` is low.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: bus-wait limit, in cycles. Used only with `DMEM_BRIDGE_TIMEOUT_EN`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_cpu`  in  1  CPU clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_mem_read`  in  1  load in the current instruction.
- `cpu_mem_write`  in  1  store in the current instruction.
- `cpu_addr`  in  32  byte address from the ALU.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid in the DONE cycle.
- `cpu_stall`  out  1  freezes PC and register write.
- `mem_req`  out  1  bus request, registered.
- `mem_we`  out  1  1 = write, registered.
- `mem_addr`  out  32  latched word address, with bits [1:0] forced to 0.
- `mem_wdata`  out  32  latched store data.
- `mem_gnt`  in  1  RAM accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `align_err`  out  1  one-cycle pulse on a misaligned access.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- States:
  - IDLE: waits for a CPU access.
  - REQ: drives `mem_req` until granted.
  - WAIT_R: waits for read data.
  - DONE: one cycle; releases the CPU.
- IDLE, with `cpu_mem_read` or `cpu_mem_write` set and `cpu_addr[1:0]` = 0:
  - latch address, write data and `we` (write wins if both are set);
  - go to REQ.
- IDLE with a misaligned access:
  - no bus access and no stall;
  - `align_err` pulses in the same cycle (combinational);
  - `cpu_rdata` = 0;
  - the store is dropped.
- REQ, `mem_req` = 1:
  - on `mem_gnt` with a write: go to DONE.
  - on `mem_gnt` with a read: if `mem_rvalid` is also high, capture `mem_rdata` and go to DONE; otherwise go to WAIT_R.
- WAIT_R, `mem_req` = 0:
  - on `mem_rvalid`, capture `mem_rdata` into `cpu_rdata` and go to DONE.
  - `mem_rvalid` outside REQ and WAIT_R is ignored.
- DONE:
  - `cpu_stall` = 0 and `cpu_rdata` holds the captured word;
  - always go to IDLE. A back-to-back access is detected in the following IDLE cycle.
- `cpu_stall` = (IDLE and an aligned access is requested) or REQ or WAIT_R. It is combinational from the inputs and state.
- Reset values:
  - state IDLE;
  - `mem_req`, `mem_we` = 0;
  - `mem_addr`, `mem_wdata`, `cpu_rdata` = 0;
  - `timeout_err` = 0.
- Reset mid-transaction: return to IDLE on that edge and drop `mem_req`. A late `mem_rvalid` is ignored.

## Timing
- The request is seen in cycle N (stall high). `mem_req` is high from N+1.
- Write granted at N+1: DONE at N+2, so 2 stall cycles.
- Read granted at N+1 with `mem_rvalid` at N+2: DONE at N+3, so 3 stall cycles. With `mem_rvalid` coincident with the grant: DONE at N+2.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable from the first REQ cycle until the grant.

## Configuration
- `DMEM_BRIDGE_TIMEOUT_EN` defined:
  - a counter clears on entry to REQ and increments each cycle in REQ or WAIT_R;
  - when it reaches `TIMEOUT_CYCLES`: drop `mem_req`, go to DONE with `cpu_rdata` = 0, set `timeout_err` (cleared only by reset).
- Macro undefined:
  - no counter; the bridge waits indefinitely;
  - `timeout_err` is tied to 0.

## Structure
- Package `dmem_bridge_pkg`: state enum (IDLE, REQ, WAIT_R, DONE), the `TIMEOUT_CYCLES` default, and the word-alignment mask constant.
- One sub-module, `dmem_timeout_ctr` (clear, enable, expired), instantiated only under the macro.

## Test plan
- Store: addr 0x10, data 0xCAFEF00D, grant at first REQ cycle -> write on bus with `mem_we` = 1; stall for 2 cycles; no `align_err`.
- Load: addr 0x20, grant delayed 3 cycles, `mem_rvalid` 2 cycles later with 0x12345678 -> `cpu_rdata` = 0x12345678 in DONE; `mem_req` held stable through the wait.
- Misaligned load at 0x22 -> `align_err` pulse, stall 0, no `mem_req`, `cpu_rdata` = 0.
- Back-to-back load then store -> second request starts in the IDLE cycle after DONE; bus order preserved.
- Reset asserted in WAIT_R, then a late `mem_rvalid` -> IDLE, outputs at reset values, late data ignored.
- With the macro and `TIMEOUT_CYCLES` = 8, no grant -> DONE after 8 wait cycles, `timeout_err` = 1 and stays set until reset.
